// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 op codes, FSM states
// and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_op1(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_op2(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_divider_core.sv
// Restoring unsigned divider: one quotient bit per cycle for WIDTH cycles,
// done pulses for one cycle after the last iteration.
module muldiv_divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Partial remainder gains the next dividend bit, then try to subtract.
    always_comb begin
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_reg  <= '0;
                quo_reg  <= dividend;
                dvs_reg  <= divisor;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                if (!diff[WIDTH]) begin
                    rem_reg <= diff[WIDTH-1:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_reg <= shifted[WIDTH-1:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                end
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    cnt_reg  <= '0;
                    busy_reg <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    logic             accept;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_res;

    assign o_ready = (state_reg == S_IDLE);
    assign accept  = i_valid && o_ready && !i_flush;

    always_comb begin
        sign1       = is_signed_op1(i_op) & i_op1[WIDTH-1];
        sign2       = is_signed_op2(i_op) & i_op2[WIDTH-1];
        mag1        = sign1 ? (~i_op1 + 1'b1) : i_op1;
        mag2        = sign2 ? (~i_op2 + 1'b1) : i_op2;
        div_zero    = (i_op2 == '0);
        div_ovf     = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_op1 == MOST_NEG) && (i_op2 == '1);
        special_res = div_zero ? (is_rem_op(i_op) ? i_op1 : '1)
                               : (is_rem_op(i_op) ? '0 : i_op1);
        div_start   = accept && is_div_op(i_op) && !div_zero && !div_ovf;
        div_res     = is_rem_op(op_reg) ? (neg_r_reg ? (~div_rem + 1'b1) : div_rem)
                                        : (neg_q_reg ? (~div_quo + 1'b1) : div_quo);
    end

    muldiv_divider_core #(.WIDTH(WIDTH)) u_div (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .abort     (i_flush),
        .start     (div_start),
        .dividend  (mag1),
        .divisor   (mag2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [WIDTH-1:0]   fast_res;

    // Sign-extending to 2*WIDTH makes the modulo product exact for every signedness mix.
    always_comb begin
        fast_prod = {{WIDTH{sign1}}, i_op1} * {{WIDTH{is_signed_op2(i_op) & i_op2[WIDTH-1]}}, i_op2};
        fast_res  = (i_op == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`else
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mul_res;

    always_comb begin
        prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
        mul_res  = (op_reg == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_MUL;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            o_valid   <= 1'b0;
            o_result  <= '0;
`ifndef MULDIV_FAST_MUL_EN
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
`endif
        end else if (i_flush) begin
            state_reg <= S_IDLE;
            o_valid   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg    <= i_op;
                        neg_q_reg <= sign1 ^ sign2;
                        neg_r_reg <= sign1;
                        if (is_div_op(i_op)) begin
                            if (div_zero || div_ovf) begin
                                o_result  <= special_res;
                                o_valid   <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                state_reg <= S_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            o_result  <= fast_res;
                            o_valid   <= 1'b1;
                            state_reg <= S_DONE;
`else
                            mcand_reg  <= {{WIDTH{1'b0}}, mag1};
                            mplier_reg <= mag2;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    state_reg <= S_IDLE;
`else
                    // WIDTH shift-add edges, then one edge for sign fixup and transfer.
                    if (cnt_reg != CNT_W'(WIDTH)) begin
                        if (mplier_reg[0]) begin
                            acc_reg <= acc_reg + mcand_reg;
                        end
                        mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                        cnt_reg    <= cnt_reg + 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        o_result  <= mul_res;
                        o_valid   <= 1'b1;
                        state_reg <= S_DONE;
                    end
`endif
                end
                S_DIV: begin
                    if (div_done) begin
                        o_result  <= div_res;
                        o_valid   <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32); honours MULDIV_FAST_MUL_EN
// when choosing the expected multiply latency.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready_out;
    logic [2:0]  op = 3'b000;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .o_ready  (ready_out),
        .i_op     (op),
        .i_op1    (op1),
        .i_op2    (op2),
        .i_flush  (flush),
        .o_valid  (res_valid),
        .i_ready  (res_ready),
        .o_result (result)
    );

    // Drives one request, scrambles the operand inputs once accepted, and
    // reports edges from acceptance to o_valid (capped at 100).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic acc);
        @(negedge clk);
        op = o; op1 = a; op2 = b; valid = 1'b1;
        #1 acc = ready_out;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op1 = 32'hDEADBEEF; op2 = 32'h0; op = ~o;
        lat = 0;
        res = 'x;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid) break;
        end
        res = result;
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    endtask

    task automatic test_ops();
        logic [2:0]  t_op  [12] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                                    OP_MULH, OP_MULHSU, OP_MULHU, OP_MUL, OP_DIVU, OP_REM};
        logic [31:0] t_a   [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000,
                                    32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd7};
        logic [31:0] t_b   [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE};
        logic [31:0] t_exp [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0,
                                    32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd14, 32'd1};
        int          t_lat [12] = '{DIV_LAT, DIV_LAT, 1, 1, 1, 1,
                                    MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT, DIV_LAT, DIV_LAT};
        int lat;
        logic [31:0] res;
        logic acc;
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, res, acc);
            $display("op=%0d a=%h b=%h result=%h latency=%0d", t_op[i], t_a[i], t_b[i], res, lat);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL op%0d_ready got=%b want=1", i, acc); end
            total++; if (res !== t_exp[i]) begin bad++; $display("FAIL op%0d_result got=%h want=%h", i, res, t_exp[i]); end
            total++; if (lat != t_lat[i]) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, t_lat[i]); end
            consume();
            total++; if (ready_out !== 1'b1 || res_valid !== 1'b0) begin
                bad++; $display("FAIL op%0d_release got ready=%b valid=%b want ready=1 valid=0", i, ready_out, res_valid);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [31:0] res;
        logic acc;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, res, acc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (res_valid !== 1'b1 || result !== 32'd14 || ready_out !== 1'b0) begin
                bad++; $display("FAIL hold%0d got valid=%b result=%h ready=%b want 1/0000000e/0", i, res_valid, result, ready_out);
            end
        end
        consume();
        $display("hold done ready=%b valid=%b", ready_out, res_valid);
        total++; if (ready_out !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", ready_out, res_valid);
        end
    endtask

    // Aborts a DIV 10 edges in, either with flush or with reset, then runs MUL 3x5.
    task automatic test_abort(input logic use_reset);
        int lat;
        logic [31:0] res;
        logic acc;
        logic seen = 1'b0;
        @(negedge clk);
        op = OP_DIV; op1 = 32'hFFFFFFF9; op2 = 32'd2; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (res_valid) seen = 1'b1;
        end
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; flush = 1'b0;
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL abort%0d_ready got=%b want=1", use_reset, ready_out); end
        repeat (40) begin
            @(posedge clk);
            #1 if (res_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort%0d_valid got=1 want=0", use_reset); end
        run_op(OP_MUL, 32'd3, 32'd5, lat, res, acc);
        $display("abort mode=%0d then MUL result=%h latency=%0d", use_reset, res, lat);
        total++; if (res !== 32'd15) begin bad++; $display("FAIL abort%0d_mul got=%h want=0000000f", use_reset, res); end
        total++; if (lat != MUL_LAT) begin bad++; $display("FAIL abort%0d_mul_lat got=%0d want=%0d", use_reset, lat, MUL_LAT); end
        consume();
    endtask

    task automatic test_flush_vs_valid();
        @(negedge clk);
        op = OP_DIVU; op1 = 32'd9; op2 = 32'd3; valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        $display("flush+valid ready=%b", ready_out);
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL flush_wins got ready=%b want=1", ready_out); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_wins_valid got=%b want=0", res_valid); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_hold();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_vs_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
